// File: rtl/button_rr_arbiter_pkg.sv
// button_rr_arbiter_pkg: shared types, sizes and the round-robin pick helper
package button_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
  // First set bit of pend searching ptr+1, ptr+2, ... wrapping modulo NUM_REQ
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] pend, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/button_rr_arbiter_if.sv
// button_rr_arbiter_if: request/tick inputs and grant outputs of the arbiter
interface button_rr_arbiter_if;
  import button_rr_arbiter_pkg::*;
  logic               tick_i;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] grant_o;
  logic [1:0]         grant_idx_o;
  logic               busy_o;
  logic [3:0]         grant_count_o;
  modport master (output tick_i, req_i, input grant_o, grant_idx_o, busy_o, grant_count_o);
  modport slave  (input tick_i, req_i, output grant_o, grant_idx_o, busy_o, grant_count_o);
endinterface

// File: rtl/button_rr_arbiter_hold_timer.sv
// hold_timer: loadable down-counter advanced by divider ticks, flags the last tick
module hold_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic               expire_o
);
  logic [TIMER_W-1:0] cnt;
  assign expire_o = tick_i && cnt == TIMER_W'(1);
  // Load wins over a same-cycle tick; counting stops at zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load_i) cnt <= load_val_i;
    else if (tick_i && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/button_rr_arbiter.sv
// button_rr_arbiter: edge-triggered round-robin grant of one resource among four buttons
module button_rr_arbiter
  import button_rr_arbiter_pkg::*;
#(
  parameter int HOLD_TICKS = 4,
  parameter int TIMER_W    = 8
) (
  input logic                clk,
  input logic                rst,
  button_rr_arbiter_if.slave bus
);
  arb_state_t         state;
  logic [NUM_REQ-1:0] req_q, pend, rise, start_oh;
  logic [1:0]         ptr, sel;
  logic               start, expire;
  assign rise     = bus.req_i & ~req_q;
  assign sel      = rr_pick(pend, ptr);
  assign start    = state == IDLE && pend != '0;
  assign start_oh = start ? NUM_REQ'(1) << sel : '0;
  hold_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start),
    .load_val_i (TIMER_W'(HOLD_TICKS)),
    .tick_i     (bus.tick_i),
    .expire_o   (expire)
  );
  // Edge capture, pending queue, grant FSM and registered outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state             <= IDLE;
      req_q             <= '0;
      pend              <= '0;
      ptr               <= 2'd3;
      bus.grant_o       <= '0;
      bus.grant_idx_o   <= '0;
      bus.busy_o        <= 1'b0;
      bus.grant_count_o <= '0;
    end else begin
      req_q <= bus.req_i;
      pend  <= (pend | rise) & ~start_oh;
      case (state)
        IDLE:
          if (start) begin
            state             <= GRANT;
            bus.grant_o       <= start_oh;
            bus.grant_idx_o   <= sel;
            bus.busy_o        <= 1'b1;
            bus.grant_count_o <= bus.grant_count_o + 1'b1;
          end else bus.busy_o <= 1'b0;
        GRANT:
          if (expire) begin
            state       <= RELEASE;
            bus.grant_o <= '0;
            bus.busy_o  <= 1'b0;
            ptr         <= bus.grant_idx_o;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_button_rr_arbiter.sv
// tb_button_rr_arbiter: directed scenario tests for the round-robin button arbiter
module tb_button_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_en = 1'b0;
  int   phase = 0;
  int   passed = 0;
  int   total = 0;
  always #5 clk = ~clk;
  button_rr_arbiter_if bus();
  button_rr_arbiter #(.HOLD_TICKS(4), .TIMER_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step;
    @(posedge clk);
    #1;
    if (tick_en) phase = (phase == 9) ? 0 : phase + 1;
    bus.tick_i = tick_en && phase == 9;
  endtask

  task automatic wait_grant;
    for (int i = 0; i < 1000 && bus.grant_o == 4'b0000; i++) step();
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 1000 && bus.grant_o != 4'b0000; i++) step();
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus.req_i = 4'b0000;
    tick_en = 1'b0;
    phase = 0;
    bus.tick_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    step();
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL rst_grant got %b want 0000", bus.grant_o); else passed++;
    total++; if (bus.grant_idx_o !== 2'd0) $display("FAIL rst_idx got %0d want 0", bus.grant_idx_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy_o); else passed++;
    total++; if (bus.grant_count_o !== 4'd0) $display("FAIL rst_count got %0d want 0", bus.grant_count_o); else passed++;
    do_reset();
    bus.req_i = 4'b0001;
    step();
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL first_lat1 got %b want 0000", bus.grant_o); else passed++;
    step();
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL first_lat2 got %b want 0001", bus.grant_o); else passed++;
    total++; if (bus.grant_count_o !== 4'd1) $display("FAIL first_count got %0d want 1", bus.grant_count_o); else passed++;
    bus.req_i = 4'b1000;
    step();
    #1 rst = 1'b0;
    #1;
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL async_grant got %b want 0000", bus.grant_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL async_busy got %b want 0", bus.busy_o); else passed++;
    total++; if (bus.grant_count_o !== 4'd0) $display("FAIL async_count got %0d want 0", bus.grant_count_o); else passed++;
    bus.req_i = 4'b0000;
    step();
    step();
    rst = 1'b1;
    tick_en = 1'b1;
    repeat (100) step();
    total++; if (bus.grant_count_o !== 4'd0) $display("FAIL pend_cleared got %0d want 0", bus.grant_count_o); else passed++;
  endtask

  task automatic test_hold;
    int ticks = 0;
    int bad = 0;
    do_reset();
    tick_en = 1'b1;
    bus.req_i = 4'b0100;
    step();
    wait_grant();
    total++; if (bus.grant_o !== 4'b0100) $display("FAIL hold_grant got %b want 0100", bus.grant_o); else passed++;
    total++; if (bus.grant_idx_o !== 2'd2) $display("FAIL hold_idx got %0d want 2", bus.grant_idx_o); else passed++;
    total++; if (bus.busy_o !== 1'b1) $display("FAIL hold_busy got %b want 1", bus.busy_o); else passed++;
    for (int i = 0; i < 200 && bus.grant_o != 4'b0000; i++) begin
      if (bus.tick_i && bus.grant_o == 4'b0100) ticks++;
      step();
      if (bus.busy_o !== (bus.grant_o != 4'b0000)) bad++;
    end
    total++; if (ticks != 4) $display("FAIL hold_ticks got %0d want 4", ticks); else passed++;
    total++; if (bad != 0) $display("FAIL hold_busy_track got %0d bad cycles want 0", bad); else passed++;
    total++; if (bus.grant_idx_o !== 2'd2) $display("FAIL hold_idx_keep got %0d want 2", bus.grant_idx_o); else passed++;
    step();
    total++; if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) $display("FAIL hold_release got %b/%b want 0000/0", bus.grant_o, bus.busy_o); else passed++;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    tick_en = 1'b1;
    bus.req_i = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      total++; if (bus.grant_o !== exp_g[i]) $display("FAIL rr_%0d got %b want %b", i, bus.grant_o, exp_g[i]); else passed++;
      wait_idle();
    end
    total++; if (bus.grant_count_o !== 4'd4) $display("FAIL rr_count got %0d want 4", bus.grant_count_o); else passed++;
    total++; if (bus.grant_idx_o !== 2'd3) $display("FAIL rr_idx got %0d want 3", bus.grant_idx_o); else passed++;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    do_reset();
    tick_en = 1'b1;
    bus.req_i = 4'b1001;
    step();
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      total++; if (bus.grant_o !== exp_g[i]) $display("FAIL fair_%0d got %b want %b", i, bus.grant_o, exp_g[i]); else passed++;
      bus.req_i = 4'b0000;
      step();
      bus.req_i = 4'b1001;
      step();
      wait_idle();
    end
  endtask

  task automatic test_held_button;
    do_reset();
    tick_en = 1'b1;
    bus.req_i = 4'b0010;
    step();
    wait_grant();
    total++; if (bus.grant_o !== 4'b0010) $display("FAIL held_first got %b want 0010", bus.grant_o); else passed++;
    repeat (150) step();
    total++; if (bus.grant_count_o !== 4'd1) $display("FAIL held_once got %0d want 1", bus.grant_count_o); else passed++;
    bus.req_i = 4'b0000;
    step();
    bus.req_i = 4'b0010;
    step();
    wait_grant();
    total++; if (bus.grant_o !== 4'b0010) $display("FAIL held_again got %b want 0010", bus.grant_o); else passed++;
    total++; if (bus.grant_count_o !== 4'd2) $display("FAIL held_count got %0d want 2", bus.grant_count_o); else passed++;
  endtask

  task automatic test_wrap;
    do_reset();
    tick_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.req_i = 4'b0001;
      step();
      bus.req_i = 4'b0000;
      wait_grant();
      wait_idle();
    end
    total++; if (bus.grant_count_o !== 4'd1) $display("FAIL wrap_count got %0d want 1", bus.grant_count_o); else passed++;
  endtask

  task automatic test_start_cycle_rise;
    do_reset();
    tick_en = 1'b1;
    bus.req_i = 4'b0010;
    step();
    wait_grant();
    bus.req_i = 4'b0011;
    step();
    bus.req_i = 4'b0010;
    step();
    wait_idle();
    step();
    bus.req_i = 4'b0011;
    step();
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL start_rise_grant got %b want 0001", bus.grant_o); else passed++;
    wait_idle();
    repeat (100) step();
    total++; if (bus.grant_count_o !== 4'd2) $display("FAIL start_rise_consumed got %0d want 2", bus.grant_count_o); else passed++;
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL start_rise_idle got %b want 0000", bus.grant_o); else passed++;
  endtask

  initial begin
    bus.req_i = 4'b0000;
    bus.tick_i = 1'b0;
    test_reset();
    test_hold();
    test_round_robin();
    test_fairness();
    test_held_button();
    test_wrap();
    test_start_cycle_rise();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
